// File: rtl/jtdd_rom_arb.sv
// Three-way ROM read arbiter onto a single 16-bit SDRAM read port.
// Each requester owns a one-word cache; misses are served by a round-robin
// fetch FSM that fills the requesting slot's cache line.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no fetch in flight; pick a missing slot round-robin
// S_WAIT_ACK  | sdram_req high, waiting for the controller to accept
// S_WAIT_DATA | request accepted, waiting for the read word
// S_FILL      | write captured word, tag and valid into the selected slot
module jtdd_rom_arb #(
   parameter int              AW0     = 18,
   parameter int              AW1     = 15,
   parameter int              AW2     = 14,
   parameter int              SDW     = 22,
   parameter logic [SDW-1:0]  OFFSET1 = 22'h2_0000,
   parameter logic [SDW-1:0]  OFFSET2 = 22'h2_4000
)(
   input  logic           clk,
   input  logic           rstn,
   input  logic           rom0_cs,
   input  logic [AW0-1:0] rom0_addr,
   output logic [7:0]     rom0_data,
   output logic           rom0_ok,
   input  logic           rom1_cs,
   input  logic [AW1-1:0] rom1_addr,
   output logic [7:0]     rom1_data,
   output logic           rom1_ok,
   input  logic           rom2_cs,
   input  logic [AW2-1:0] rom2_addr,
   output logic [7:0]     rom2_data,
   output logic           rom2_ok,
   output logic           sdram_req,
   output logic [SDW-1:0] sdram_addr,
   input  logic           sdram_ack,
   input  logic           data_rdy,
   input  logic [15:0]    sdram_din
);
   // Widest word-tag across the three slots; narrower tags are zero-extended.
   localparam int AWM = (AW0 > AW1) ? ((AW0 > AW2) ? AW0 : AW2)
                                    : ((AW1 > AW2) ? AW1 : AW2);
   localparam int TW  = AWM - 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DATA, S_FILL} state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [SDW-1:0]   sdram_addr_q, sdram_addr_d;
   logic [TW-1:0]    fetch_tag_q, fetch_tag_d;
   logic [15:0]      din_q, din_d;
   logic [2:0]       valid_q, valid_d;
   logic [15:0]      word0_q, word0_d, word1_q, word1_d, word2_q, word2_d;
   logic [AW0-2:0]   tag0_q, tag0_d;
   logic [AW1-2:0]   tag1_q, tag1_d;
   logic [AW2-2:0]   tag2_q, tag2_d;

   logic [2:0]       hit, miss;
   logic [SDW-1:0]   map0, map1, map2;
   logic [1:0]       rr1, rr2, pick;
   logic             found;

   assign hit[0] = valid_q[0] && (tag0_q == rom0_addr[AW0-1:1]);
   assign hit[1] = valid_q[1] && (tag1_q == rom1_addr[AW1-1:1]);
   assign hit[2] = valid_q[2] && (tag2_q == rom2_addr[AW2-1:1]);
   assign miss   = {rom2_cs, rom1_cs, rom0_cs} & ~hit;

   assign rom0_ok   = rom0_cs & hit[0];
   assign rom1_ok   = rom1_cs & hit[1];
   assign rom2_ok   = rom2_cs & hit[2];
   assign rom0_data = rom0_addr[0] ? word0_q[15:8] : word0_q[7:0];
   assign rom1_data = rom1_addr[0] ? word1_q[15:8] : word1_q[7:0];
   assign rom2_data = rom2_addr[0] ? word2_q[15:8] : word2_q[7:0];

   assign map0 = SDW'(rom0_addr[AW0-1:1]);
   assign map1 = OFFSET1 + SDW'(rom1_addr[AW1-1:1]);
   assign map2 = OFFSET2 + SDW'(rom2_addr[AW2-1:1]);

   assign sdram_req  = (state_q == S_WAIT_ACK);
   assign sdram_addr = sdram_addr_q;

   // Round-robin pick: first missing slot at or after rr_ptr, modulo 3.
   always_comb begin
      rr1   = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
      rr2   = (rr1 == 2'd2) ? 2'd0 : rr1 + 2'd1;
      found = 1'b1;
      pick  = rr_ptr_q;
      if (miss[rr_ptr_q])  pick = rr_ptr_q;
      else if (miss[rr1])  pick = rr1;
      else if (miss[rr2])  pick = rr2;
      else                 found = 1'b0;
   end

   // Next-state and datapath/cache updates.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      rr_ptr_d     = rr_ptr_q;
      sdram_addr_d = sdram_addr_q;
      fetch_tag_d  = fetch_tag_q;
      din_d        = din_q;
      valid_d      = valid_q;
      word0_d      = word0_q;
      word1_d      = word1_q;
      word2_d      = word2_q;
      tag0_d       = tag0_q;
      tag1_d       = tag1_q;
      tag2_d       = tag2_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               sel_d   = pick;
               state_d = S_WAIT_ACK;
               case (pick)
                  2'd1: begin
                     sdram_addr_d = map1;
                     fetch_tag_d  = TW'(rom1_addr[AW1-1:1]);
                  end
                  2'd2: begin
                     sdram_addr_d = map2;
                     fetch_tag_d  = TW'(rom2_addr[AW2-1:1]);
                  end
                  default: begin
                     sdram_addr_d = map0;
                     fetch_tag_d  = TW'(rom0_addr[AW0-1:1]);
                  end
               endcase
            end
         end
         S_WAIT_ACK: begin
            if (sdram_ack) begin
               if (data_rdy) begin
                  din_d   = sdram_din;
                  state_d = S_FILL;
               end else begin
                  state_d = S_WAIT_DATA;
               end
            end
         end
         S_WAIT_DATA: begin
            if (data_rdy) begin
               din_d   = sdram_din;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            // Tag comes from the address latched at request time, so a
            // requester that moved on mid-fetch will simply miss again.
            case (sel_q)
               2'd1: begin
                  word1_d    = din_q;
                  tag1_d     = fetch_tag_q[AW1-2:0];
                  valid_d[1] = 1'b1;
               end
               2'd2: begin
                  word2_d    = din_q;
                  tag2_d     = fetch_tag_q[AW2-2:0];
                  valid_d[2] = 1'b1;
               end
               default: begin
                  word0_d    = din_q;
                  tag0_d     = fetch_tag_q[AW0-2:0];
                  valid_d[0] = 1'b1;
               end
            endcase
            rr_ptr_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Fetch bookkeeping and per-slot cache registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_q        <= 2'd0;
         rr_ptr_q     <= 2'd0;
         sdram_addr_q <= '0;
         fetch_tag_q  <= '0;
         din_q        <= 16'h0000;
         valid_q      <= 3'b000;
         word0_q      <= 16'h0000;
         word1_q      <= 16'h0000;
         word2_q      <= 16'h0000;
         tag0_q       <= '0;
         tag1_q       <= '0;
         tag2_q       <= '0;
      end else begin
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         sdram_addr_q <= sdram_addr_d;
         fetch_tag_q  <= fetch_tag_d;
         din_q        <= din_d;
         valid_q      <= valid_d;
         word0_q      <= word0_d;
         word1_q      <= word1_d;
         word2_q      <= word2_d;
         tag0_q       <= tag0_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
      end
   end
endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: expected SDRAM word addresses are queued as
// requests are provoked and popped when the DUT raises sdram_req.
module tb_jtdd_rom_arb;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rom0_cs = 1'b0, rom1_cs = 1'b0, rom2_cs = 1'b0;
   logic [17:0] rom0_addr = '0;
   logic [14:0] rom1_addr = '0;
   logic [13:0] rom2_addr = '0;
   logic [7:0]  rom0_data, rom1_data, rom2_data;
   logic        rom0_ok, rom1_ok, rom2_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack = 1'b0;
   logic        data_rdy = 1'b0;
   logic [15:0] sdram_din = 16'h0000;

   int checks = 0;
   int errors = 0;
   logic [21:0] exp_addr_q[$];

   jtdd_rom_arb dut (
      .clk(clk), .rstn(rstn),
      .rom0_cs(rom0_cs), .rom0_addr(rom0_addr), .rom0_data(rom0_data), .rom0_ok(rom0_ok),
      .rom1_cs(rom1_cs), .rom1_addr(rom1_addr), .rom1_data(rom1_data), .rom1_ok(rom1_ok),
      .rom2_cs(rom2_cs), .rom2_addr(rom2_addr), .rom2_data(rom2_data), .rom2_ok(rom2_ok),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .data_rdy(data_rdy), .sdram_din(sdram_din)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait for a request, compare its address with the scoreboard, then ack.
   task automatic serve_req(input int ack_dly, input bit with_data, input logic [15:0] word);
      int n = 0;
      logic [21:0] exp;
      while (sdram_req !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
      checks++;
      if (sdram_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: sdram_req=%b required 1", sdram_req);
         return;
      end
      checks++;
      if (exp_addr_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_req: sdram_addr=%h required no request", sdram_addr);
      end else begin
         exp = exp_addr_q.pop_front();
         if (sdram_addr !== exp) begin
            errors++;
            $display("FAIL req_addr: sdram_addr=%h required %h", sdram_addr, exp);
         end
      end
      for (int i = 1; i < ack_dly; i++) begin
         tick;
         checks++;
         if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL req_hold: sdram_req=%b required 1", sdram_req);
         end
      end
      sdram_ack = 1'b1;
      if (with_data) begin
         data_rdy  = 1'b1;
         sdram_din = word;
      end
      tick;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      checks++;
      if (sdram_req !== 1'b0) begin
         errors++;
         $display("FAIL req_after_ack: sdram_req=%b required 0", sdram_req);
      end
   endtask

   task automatic serve_data(input int data_dly, input logic [15:0] word);
      for (int i = 1; i < data_dly; i++) tick;
      data_rdy  = 1'b1;
      sdram_din = word;
      tick;
      data_rdy  = 1'b0;
      sdram_din = 16'h0000;
   endtask

   task automatic test_reset;
      rom0_cs = 1'b1; rom1_cs = 1'b1; rom2_cs = 1'b1;
      rom0_addr = 18'h00003; rom1_addr = 15'h0011; rom2_addr = 14'h0101;
      #1;
      checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", sdram_req); end
      checks++; if (sdram_addr !== 22'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", sdram_addr); end
      checks++; if ({rom2_ok, rom1_ok, rom0_ok} !== 3'b000) begin errors++; $display("FAIL rst_ok: got %b required 000", {rom2_ok, rom1_ok, rom0_ok}); end
      checks++; if ({rom2_data, rom1_data, rom0_data} !== 24'h0) begin errors++; $display("FAIL rst_data: got %h required 000000", {rom2_data, rom1_data, rom0_data}); end
      rom0_cs = 1'b0; rom1_cs = 1'b0; rom2_cs = 1'b0;
   endtask

   task automatic test_single_miss;
      rom0_addr = 18'h00005; rom0_cs = 1'b1;
      exp_addr_q.push_back(22'h000002);
      serve_req(2, 1'b0, 16'h0);
      serve_data(3, 16'hBEEF);
      checks++; if (rom0_ok !== 1'b0) begin errors++; $display("FAIL single_fill_ok: got %b required 0", rom0_ok); end
      tick;
      checks++; if (rom0_ok !== 1'b1) begin errors++; $display("FAIL single_ok: got %b required 1", rom0_ok); end
      checks++; if (rom0_data !== 8'hBE) begin errors++; $display("FAIL single_data_hi: got %h required be", rom0_data); end
      rom0_addr = 18'h00004;
      #1;
      checks++; if (rom0_ok !== 1'b1) begin errors++; $display("FAIL single_hit_ok: got %b required 1", rom0_ok); end
      checks++; if (rom0_data !== 8'hEF) begin errors++; $display("FAIL single_hit_data: got %h required ef", rom0_data); end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL single_no_req: got %b required 0", sdram_req); end
      end
      rom0_cs = 1'b0;
   endtask

   task automatic test_offset;
      rom1_addr = 15'h0010; rom1_cs = 1'b1;
      exp_addr_q.push_back(22'h020008);
      serve_req(1, 1'b0, 16'h0);
      serve_data(1, 16'h1234);
      tick;
      checks++; if (rom1_ok !== 1'b1 || rom1_data !== 8'h34) begin errors++; $display("FAIL off1_hit: ok=%b data=%h required 1/34", rom1_ok, rom1_data); end
      rom1_cs = 1'b0;
      rom2_addr = 14'h3FFF; rom2_cs = 1'b1;
      exp_addr_q.push_back(22'h025FFF);
      serve_req(3, 1'b0, 16'h0);
      serve_data(2, 16'hA55A);
      tick;
      checks++; if (rom2_ok !== 1'b1 || rom2_data !== 8'hA5) begin errors++; $display("FAIL off2_hit: ok=%b data=%h required 1/a5", rom2_ok, rom2_data); end
      rom2_cs = 1'b0;
      repeat (3) tick;
      checks++; if (sdram_addr !== 22'h025FFF || sdram_req !== 1'b0) begin errors++; $display("FAIL idle_hold: addr=%h req=%b required 025fff/0", sdram_addr, sdram_req); end
   endtask

   task automatic test_round_robin;
      rom0_addr = 18'h00101; rom1_addr = 15'h0020; rom2_addr = 14'h0002;
      rom0_cs = 1'b1; rom1_cs = 1'b1; rom2_cs = 1'b1;
      exp_addr_q.push_back(22'h000080);
      exp_addr_q.push_back(22'h020010);
      exp_addr_q.push_back(22'h024001);
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h1100); tick;
      checks++; if (rom0_ok !== 1'b1 || rom0_data !== 8'h11) begin errors++; $display("FAIL rr0: ok=%b data=%h required 1/11", rom0_ok, rom0_data); end
      serve_req(2, 1'b0, 16'h0); serve_data(2, 16'h2233); tick;
      checks++; if (rom1_ok !== 1'b1 || rom1_data !== 8'h33) begin errors++; $display("FAIL rr1: ok=%b data=%h required 1/33", rom1_ok, rom1_data); end
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h4455); tick;
      checks++; if ({rom2_ok, rom1_ok, rom0_ok} !== 3'b111 || rom2_data !== 8'h55) begin errors++; $display("FAIL rr_all: ok=%b data2=%h required 111/55", {rom2_ok, rom1_ok, rom0_ok}, rom2_data); end
      // After slot 2 the pointer wraps, so slot 0 must win over slot 1.
      rom0_addr = 18'h00200; rom1_addr = 15'h0040;
      exp_addr_q.push_back(22'h000100);
      exp_addr_q.push_back(22'h020020);
      serve_req(1, 1'b0, 16'h0);
      checks++; if (rom2_ok !== 1'b1) begin errors++; $display("FAIL rr_other_hit: ok2=%b required 1", rom2_ok); end
      serve_data(1, 16'h6677); tick;
      checks++; if (rom0_ok !== 1'b1 || rom0_data !== 8'h77) begin errors++; $display("FAIL rr_wrap0: ok=%b data=%h required 1/77", rom0_ok, rom0_data); end
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h8899); tick;
      checks++; if (rom1_ok !== 1'b1 || rom1_data !== 8'h99) begin errors++; $display("FAIL rr_wrap1: ok=%b data=%h required 1/99", rom1_ok, rom1_data); end
      rom0_cs = 1'b0; rom1_cs = 1'b0; rom2_cs = 1'b0;
   endtask

   task automatic test_addr_change;
      rom1_addr = 15'h0100; rom1_cs = 1'b1;
      exp_addr_q.push_back(22'h020080);
      serve_req(1, 1'b0, 16'h0);
      rom1_addr = 15'h0200;
      exp_addr_q.push_back(22'h020100);
      serve_data(2, 16'hAAAA);
      checks++; if (rom1_ok !== 1'b0) begin errors++; $display("FAIL chg_fill_ok: got %b required 0", rom1_ok); end
      tick;
      checks++; if (rom1_ok !== 1'b0) begin errors++; $display("FAIL chg_stale_ok: got %b required 0", rom1_ok); end
      serve_req(2, 1'b0, 16'h0);
      serve_data(1, 16'hC3D4);
      tick;
      checks++; if (rom1_ok !== 1'b1 || rom1_data !== 8'hD4) begin errors++; $display("FAIL chg_refetch: ok=%b data=%h required 1/d4", rom1_ok, rom1_data); end
      rom1_cs = 1'b0;
   endtask

   task automatic test_ack_data_same;
      rom2_addr = 14'h0010; rom2_cs = 1'b1;
      exp_addr_q.push_back(22'h024008);
      serve_req(2, 1'b1, 16'h5EED);
      checks++; if (rom2_ok !== 1'b0) begin errors++; $display("FAIL same_fill_ok: got %b required 0", rom2_ok); end
      tick;
      checks++; if (rom2_ok !== 1'b1 || rom2_data !== 8'hED) begin errors++; $display("FAIL same_hit: ok=%b data=%h required 1/ed", rom2_ok, rom2_data); end
      rom2_cs = 1'b0;
   endtask

   task automatic test_reset_mid;
      rom0_addr = 18'h01001; rom0_cs = 1'b1;
      exp_addr_q.push_back(22'h000800);
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h7A7B); tick;
      checks++; if (rom0_ok !== 1'b1 || rom0_data !== 8'h7A) begin errors++; $display("FAIL rm_pre: ok=%b data=%h required 1/7a", rom0_ok, rom0_data); end
      rom0_cs = 1'b0;
      rom1_addr = 15'h0300; rom1_cs = 1'b1;
      exp_addr_q.push_back(22'h020180);
      serve_req(1, 1'b0, 16'h0);
      rstn = 1'b0;
      #1;
      checks++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin errors++; $display("FAIL rm_rst: req=%b addr=%h required 0/0", sdram_req, sdram_addr); end
      checks++; if (rom1_ok !== 1'b0) begin errors++; $display("FAIL rm_rst_ok: got %b required 0", rom1_ok); end
      rom1_cs = 1'b0;
      data_rdy = 1'b1; sdram_din = 16'hFFFF;
      tick;
      data_rdy = 1'b0;
      tick;
      rstn = 1'b1;
      tick;
      data_rdy = 1'b1;
      tick;
      data_rdy = 1'b0;
      tick;
      checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rm_stray_req: got %b required 0", sdram_req); end
      rom0_cs = 1'b1; rom1_cs = 1'b1;
      #1;
      checks++; if (rom0_ok !== 1'b0 || rom1_ok !== 1'b0) begin errors++; $display("FAIL rm_cleared: ok0=%b ok1=%b required 0/0", rom0_ok, rom1_ok); end
      exp_addr_q.push_back(22'h000800);
      exp_addr_q.push_back(22'h020180);
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h0102); tick;
      checks++; if (rom0_ok !== 1'b1 || rom0_data !== 8'h01) begin errors++; $display("FAIL rm_fresh0: ok=%b data=%h required 1/01", rom0_ok, rom0_data); end
      serve_req(1, 1'b0, 16'h0); serve_data(1, 16'h0304); tick;
      checks++; if (rom1_ok !== 1'b1 || rom1_data !== 8'h04) begin errors++; $display("FAIL rm_fresh1: ok=%b data=%h required 1/04", rom1_ok, rom1_data); end
      rom0_cs = 1'b0; rom1_cs = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      rstn = 1'b1;
      tick;
      test_single_miss;
      test_offset;
      test_round_robin;
      test_addr_change;
      test_ack_data_same;
      test_reset_mid;
      checks++;
      if (exp_addr_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: %0d requests outstanding, required 0", exp_addr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
